voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NVOICE, default 4, number of simultaneous voices (2..8).
REQ-002 SHALL have parameter VOL_INIT, default 7'h78, volume after reset.
REQ-003 SHALL have parameters VOL_MIN, default 7'h30, and VOL_MAX, default 7'h7F, the volume saturation bounds.
REQ-004 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port: clrn  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port: code  input  8  PS/2 scan-code byte.
REQ-007 SHALL have port: code_valid  input  1  one-cycle strobe; code is sampled only when high.
REQ-008 SHALL have port: voice_note  output  5*NVOICE  note index 0..23 per voice; voice v occupies bits [5v+4:5v].
REQ-009 SHALL have port: voice_active  output  NVOICE  bit v high while voice v holds a pressed key.
REQ-010 SHALL have port: mono_note  output  5  note of the most recently allocated active voice.
REQ-011 SHALL have port: mono_valid  output  1  high when any voice is active.
REQ-012 SHALL have port: volume  output  7  current volume.
REQ-013 SHALL have port: vol_changed  output  1  one-cycle pulse when volume changes value.

Function
REQ-014 SHALL register all outputs; every effect of a byte SHALL be visible on the cycle after the code_valid cycle.
REQ-015 SHALL run parser FSM {IDLE, BRK, EXT, EXT_BRK}: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; EXT+other->IDLE (byte discarded); EXT_BRK+any->IDLE (discarded); BRK+any->IDLE (break event).
REQ-016 SHALL, in BRK, treat a further F0 or E0 as the break target: discard it and return to IDLE.
REQ-017 SHALL decode note keys: 15,1E,1D,26,24,2D,2E,2C,36,35,3D,3C -> notes 0..11; 2A,34,32,33,31,3A,42,41,4B,49,4C,4A -> notes 12..23.
REQ-018 SHALL, in IDLE, ignore make codes that are neither notes nor volume keys.
REQ-019 SHALL keep a per-voice rank 0..NVOICE-1 (0 = newest); ranks always form a permutation; reset ranks are voice v = v.
REQ-020 SHALL treat a note make whose note is already in an active voice as typematic repeat: no state change.
REQ-021 SHALL otherwise allocate the lowest-index inactive voice; if all voices are active, SHALL steal the voice with rank NVOICE-1.
REQ-022 SHALL, on allocation to voice v with old rank r: set voice_note[v]=note and voice_active[v]=1, set rank[v]=0, and increment every rank below r.
REQ-023 SHALL, on a note break, clear voice_active of the voice holding that note and leave ranks and voice_note unchanged; a break for an unheld note SHALL be a no-op.
REQ-024 SHALL drive mono_note from the active voice with the smallest rank; when no voice is active, mono_note SHALL hold its last value and mono_valid SHALL be 0.
REQ-025 SHALL, on a 55 make, increment volume saturating at VOL_MAX; on a 4E make, SHALL decrement volume saturating at VOL_MIN; each typematic repeat counts.
REQ-026 SHALL pulse vol_changed only when the volume value actually changes; no pulse at saturation.
REQ-027 SHALL ignore breaks of volume keys.
REQ-028 SHALL process at most one byte per cycle; code_valid on back-to-back cycles SHALL be handled with no loss.

Reset
REQ-029 SHALL, while clrn=0, put the FSM in IDLE and set voice_active=0, voice_note=0, ranks=identity, mono_note=0, mono_valid=0, volume=VOL_INIT, and vol_changed=0.
REQ-030 SHALL discard a partially parsed prefix (F0/E0) when reset is asserted mid-sequence.

Structure
REQ-031 SHALL place the scan-code prefix constants (F0, E0), volume key codes (55, 4E), the FSM state encoding and the note-index width in the shared package piano_pkg.
REQ-032 SHALL implement the decode as one combinational sub-module, scan_to_note (code -> note, is_note); the sub-module SHALL contain no state.

Verification
REQ-033 Bench SHALL cover: make 15 -> voice0 active, note 0, mono_note=0, mono_valid=1; then F0,15 -> voice_active=0, mono_valid=0.
REQ-034 Bench SHALL cover: makes 15,1D,24,2D,2C (NVOICE=4) -> fifth key steals voice0 (oldest), voice_note[0]=7, mono_note=7.
REQ-035 Bench SHALL cover: make 1D repeated three times -> one voice only and no rank change; break 1D -> released.
REQ-036 Bench SHALL cover: 55 repeated eight times from 7'h78 -> volume=7'h7F, exactly seven vol_changed pulses; 4E from 7'h30 -> no change and no pulse.
REQ-037 Bench SHALL cover: E0,F0,15 while note 0 is held -> note 0 still held, FSM back in IDLE; F0 then clrn pulse, then 15 -> treated as make.
REQ-038 Bench SHALL cover: makes 15,1D, break 1D -> mono_note falls back to 0; back-to-back code_valid bytes 15,F0,15 -> voice0 inactive on the cycle after the last byte.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared constants for the PS/2 piano: scan-code prefixes, volume keys,
// parser state encoding and note-index width.
package piano_pkg;

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_VOL_UP = 8'h55;
    localparam logic [7:0] CODE_VOL_DN = 8'h4E;

    localparam int NOTE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } parse_state_t;

endpackage

// File: rtl/scan_to_note.sv
// Stateless decode of a scan-code byte to a two-octave note index 0..23.
module scan_to_note
    import piano_pkg::*;
(
    input  logic [7:0]        code,
    output logic [NOTE_W-1:0] note,
    output logic              is_note
);

    always_comb begin
        note    = '0;
        is_note = 1'b1;
        case (code)
            8'h15: note = 5'd0;
            8'h1E: note = 5'd1;
            8'h1D: note = 5'd2;
            8'h26: note = 5'd3;
            8'h24: note = 5'd4;
            8'h2D: note = 5'd5;
            8'h2E: note = 5'd6;
            8'h2C: note = 5'd7;
            8'h36: note = 5'd8;
            8'h35: note = 5'd9;
            8'h3D: note = 5'd10;
            8'h3C: note = 5'd11;
            8'h2A: note = 5'd12;
            8'h34: note = 5'd13;
            8'h32: note = 5'd14;
            8'h33: note = 5'd15;
            8'h31: note = 5'd16;
            8'h3A: note = 5'd17;
            8'h42: note = 5'd18;
            8'h41: note = 5'd19;
            8'h4B: note = 5'd20;
            8'h49: note = 5'd21;
            8'h4C: note = 5'd22;
            8'h4A: note = 5'd23;
            default: is_note = 1'b0;
        endcase
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with LRU stealing and saturating volume,
// driven by a PS/2 scan-code stream.
module voice_allocator
    import piano_pkg::*;
#(
    parameter int         NVOICE   = 4,
    parameter logic [6:0] VOL_INIT = 7'h78,
    parameter logic [6:0] VOL_MIN  = 7'h30,
    parameter logic [6:0] VOL_MAX  = 7'h7F
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [7:0]               code,
    input  logic                     code_valid,
    output logic [NOTE_W*NVOICE-1:0] voice_note,
    output logic [NVOICE-1:0]        voice_active,
    output logic [NOTE_W-1:0]        mono_note,
    output logic                     mono_valid,
    output logic [6:0]               volume,
    output logic                     vol_changed
);

    localparam int RW = $clog2(NVOICE);
    typedef logic [RW-1:0] idx_t;

    parse_state_t state, state_nxt;
    logic make_ev, brk_ev;

    logic [NOTE_W-1:0] dec_note;
    logic              dec_is_note;

    logic [NOTE_W-1:0] note_q [NVOICE];
    logic [NOTE_W-1:0] note_n [NVOICE];
    idx_t              rank_q [NVOICE];
    idx_t              rank_n [NVOICE];
    logic [NVOICE-1:0] active_n;

    logic              hit, free_found, best_found;
    idx_t              hit_idx, free_idx, old_idx, alloc_idx, best_rank;
    logic [NOTE_W-1:0] best_note;

    scan_to_note u_dec (
        .code    (code),
        .note    (dec_note),
        .is_note (dec_is_note)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A second prefix byte right after F0 is taken as the released key and dropped.
    always_comb begin
        state_nxt = state;
        make_ev   = 1'b0;
        brk_ev    = 1'b0;
        if (code_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (code == CODE_BRK)      state_nxt = ST_BRK;
                    else if (code == CODE_EXT) state_nxt = ST_EXT;
                    else                       make_ev   = 1'b1;
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    brk_ev    = (code != CODE_BRK) && (code != CODE_EXT);
                end
                ST_EXT:     state_nxt = (code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        old_idx    = '0;
        for (int unsigned v = 0; v < NVOICE; v++) begin
            if (!hit && voice_active[v] && note_q[v] == dec_note) begin
                hit     = 1'b1;
                hit_idx = idx_t'(v);
            end
            if (!free_found && !voice_active[v]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(v);
            end
            if (rank_q[v] == idx_t'(NVOICE - 1)) old_idx = idx_t'(v);
        end
        alloc_idx = free_found ? free_idx : old_idx;

        note_n   = note_q;
        rank_n   = rank_q;
        active_n = voice_active;
        if (make_ev && dec_is_note && !hit) begin
            for (int unsigned v = 0; v < NVOICE; v++)
                if (rank_q[v] < rank_q[alloc_idx]) rank_n[v] = rank_q[v] + 1'b1;
            rank_n[alloc_idx]   = '0;
            note_n[alloc_idx]   = dec_note;
            active_n[alloc_idx] = 1'b1;
        end
        if (brk_ev && dec_is_note && hit) active_n[hit_idx] = 1'b0;

        // Mono output follows the post-update voices so it stays in step with them.
        best_found = 1'b0;
        best_rank  = '0;
        best_note  = mono_note;
        for (int unsigned v = 0; v < NVOICE; v++) begin
            if (active_n[v] && (!best_found || rank_n[v] < best_rank)) begin
                best_found = 1'b1;
                best_rank  = rank_n[v];
                best_note  = note_n[v];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned v = 0; v < NVOICE; v++) begin
                note_q[v] <= '0;
                rank_q[v] <= idx_t'(v);
            end
            voice_active <= '0;
            mono_note    <= '0;
            mono_valid   <= 1'b0;
            volume       <= VOL_INIT;
            vol_changed  <= 1'b0;
        end else begin
            note_q       <= note_n;
            rank_q       <= rank_n;
            voice_active <= active_n;
            mono_note    <= best_note;
            mono_valid   <= best_found;
            vol_changed  <= 1'b0;
            if (make_ev && code == CODE_VOL_UP && volume < VOL_MAX) begin
                volume      <= volume + 7'd1;
                vol_changed <= 1'b1;
            end else if (make_ev && code == CODE_VOL_DN && volume > VOL_MIN) begin
                volume      <= volume - 7'd1;
                vol_changed <= 1'b1;
            end
        end
    end

    always_comb begin
        voice_note = '0;
        for (int unsigned v = 0; v < NVOICE; v++)
            voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NVOICE=4) with hand-computed expectations.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  code = 8'h00;
    logic        code_valid = 1'b0;
    logic [19:0] voice_note;
    logic [3:0]  voice_active;
    logic [4:0]  mono_note;
    logic        mono_valid;
    logic [6:0]  volume;
    logic        vol_changed;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    voice_allocator #(
        .NVOICE   (4),
        .VOL_INIT (7'h78),
        .VOL_MIN  (7'h30),
        .VOL_MAX  (7'h7F)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .code         (code),
        .code_valid   (code_valid),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .mono_note    (mono_note),
        .mono_valid   (mono_valid),
        .volume       (volume),
        .vol_changed  (vol_changed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Consecutive calls land on consecutive edges, so byte sequences are back-to-back.
    task automatic put(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_active", 32'(voice_active), 32'h0);
        chk("rst_note",   32'(voice_note),   32'h0);
        chk("rst_mono",   32'({mono_valid, mono_note}), 32'h0);
        chk("rst_vol",    32'(volume),       32'h78);
        chk("rst_volchg", 32'(vol_changed),  32'h0);
        @(negedge clk);
        clrn = 1'b1;
        idle(2);

        // Single press and release
        put(8'h15);
        chk("p1_active", 32'(voice_active), 32'h1);
        chk("p1_note0",  32'(voice_note[4:0]), 32'h0);
        chk("p1_mono",   32'({mono_valid, mono_note}), 32'h20);
        put(8'hF0); put(8'h15);
        chk("r1_active", 32'(voice_active), 32'h0);
        chk("r1_mono",   32'({mono_valid, mono_note}), 32'h00);

        // Fifth key steals the oldest voice
        idle(1);
        put(8'h15); put(8'h1D); put(8'h24); put(8'h2D);
        chk("st4_mono",   32'(mono_note), 32'd5);
        put(8'h2C);
        chk("st_active",  32'(voice_active), 32'hF);
        chk("st_notes",   32'(voice_note), 32'({5'd5, 5'd4, 5'd2, 5'd7}));
        chk("st_mono",    32'({mono_valid, mono_note}), 32'h27);
        put(8'hF0); put(8'h2C);
        chk("st_fallbk",  32'({mono_valid, mono_note}), 32'h25);
        put(8'hF0); put(8'h1D); put(8'hF0); put(8'h24); put(8'hF0); put(8'h2D);
        chk("st_allrel",  32'(voice_active), 32'h0);
        chk("st_hold",    32'({mono_valid, mono_note}), 32'h05);

        // Typematic repeat and ignored non-note key
        put(8'h1D); put(8'h1D); put(8'h1D);
        chk("rep_active", 32'(voice_active), 32'h1);
        chk("rep_note",   32'(voice_note[4:0]), 32'd2);
        put(8'h1C);
        chk("ign_active", 32'(voice_active), 32'h1);
        put(8'hF0); put(8'h1D);
        chk("rep_rel",    32'({voice_active, mono_valid}), 32'h0);

        // Volume up to saturation
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            put(8'h55);
            pulses += int'(vol_changed);
        end
        chk("vup_vol",    32'(volume), 32'h7F);
        chk("vup_pulses", 32'(pulses), 32'd7);
        pulses = 0;
        for (int i = 0; i < 79; i++) begin
            put(8'h4E);
            pulses += int'(vol_changed);
        end
        chk("vdn_vol",    32'(volume), 32'h30);
        chk("vdn_pulses", 32'(pulses), 32'd79);
        put(8'h4E);
        chk("vmin_vol",   32'({vol_changed, volume}), 32'h30);
        put(8'hF0); put(8'h55);
        chk("vbrk_vol",   32'({vol_changed, volume}), 32'h30);

        // Extended break is discarded, parser returns to IDLE
        put(8'h15);
        put(8'hE0); put(8'hF0); put(8'h15);
        chk("ext_held",   32'(voice_active), 32'h1);
        put(8'h1D);
        chk("ext_idle",   32'(voice_active), 32'h3);
        put(8'hF0); put(8'h15); put(8'hF0); put(8'h1D);
        chk("ext_rel",    32'(voice_active), 32'h0);

        // Reset mid-prefix drops the pending F0
        put(8'h55);
        put(8'hF0);
        #3 clrn = 1'b0;
        #1;
        chk("arst_vol",   32'(volume), 32'h78);
        @(negedge clk);
        clrn = 1'b1;
        idle(1);
        put(8'h15);
        chk("arst_make",  32'({voice_active, mono_valid, mono_note}), 32'h60);

        // Fallback to older voice, then back-to-back bytes
        put(8'h1D);
        chk("fb_mono_new", 32'({mono_valid, mono_note}), 32'h22);
        put(8'hF0); put(8'h1D);
        chk("fb_mono_old", 32'({mono_valid, mono_note}), 32'h20);
        idle(2);
        put(8'h15); put(8'hF0); put(8'h15);
        chk("b2b_active", 32'({voice_active, mono_valid}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
